// File: rtl/templatized_alu_pipe.sv
// templatized_alu_pipe: WIDTH-generic two-stage ALU with valid/ready handshake.
// S1 latches the operands and opcode; the result is computed combinationally
// from S1 and captured in S2, which drives the output port together with the
// {Z,N,C,V} status flags and the illegal-opcode error bit. A carry register
// links consecutive add-group ops so ADDC/SUBB can chain multi-word arithmetic.
// WIDTH must be a power of two and at least 4; SH_W is derived from it.
module templatized_alu_pipe #(
   parameter int WIDTH = 16,
   parameter int SH_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags,
   output logic             err
);

   // Opcode groups, selected by op[3:2]
   localparam logic [1:0] GRP_ADD   = 2'b00;
   localparam logic [1:0] GRP_BOOL  = 2'b01;
   localparam logic [1:0] GRP_SHIFT = 2'b10;

   // Sub-opcodes within the bool and shift groups, selected by op[1:0]
   localparam logic [1:0] BOOL_AND  = 2'b00;
   localparam logic [1:0] BOOL_OR   = 2'b01;
   localparam logic [1:0] BOOL_XOR  = 2'b10;
   localparam logic [1:0] SH_SLL    = 2'b00;
   localparam logic [1:0] SH_SRL    = 2'b01;
   localparam logic [1:0] SH_SRA    = 2'b10;

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   logic [3:0]       s1_op_q,    s1_op_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] out_q,      out_d;
   logic [3:0]       flags_q,    flags_d;
   logic             err_q,      err_d;

   logic             carry_q,    carry_d;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s1_adv;
   logic accept;

   // S1 moves into S2 whenever S2 is empty or is being drained this cycle;
   // in_ready therefore depends combinationally on out_ready.
   assign s1_adv    = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready  = ~s1_valid_q | s1_adv;
   assign accept    = in_valid & in_ready;
   assign out_valid = s2_valid_q;
   assign out       = out_q;
   assign flags     = flags_q;
   assign err       = err_q;

   // ------------------------------------------------------------------
   // Execute datapath (operates on S1 contents)
   // ------------------------------------------------------------------
   logic [1:0]         grp;
   logic [1:0]         sub_op;
   logic [SH_W-1:0]    sh_amt;
   logic               arith_cin;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH:0]     sll_ext;
   logic [WIDTH:0]     srl_ext;
   logic [WIDTH:0]     sra_ext;
   logic [2*WIDTH-1:0] rol_ext;

   assign grp    = s1_op_q[3:2];
   assign sub_op = s1_op_q[1:0];
   assign sh_amt = s1_b_q[SH_W-1:0];

   // op[1] selects the carry-chaining variants (ADDC/SUBB); op[0] selects subtract.
   assign arith_cin = s1_op_q[1] & carry_q;

   // One extra bit on the arithmetic results captures carry-out / borrow.
   assign add_sum  = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, arith_cin};
   assign sub_diff = {1'b0, s1_a_q} - {1'b0, s1_b_q} - {{WIDTH{1'b0}}, arith_cin};

   // Shifts are done one bit wider than the operand so that the last bit
   // shifted out lands in the extra bit; with s==0 that bit is a zero filler.
   assign sll_ext = {1'b0, s1_a_q} << sh_amt;
   assign srl_ext = {s1_a_q, 1'b0} >> sh_amt;
   assign sra_ext = $signed({s1_a_q, 1'b0}) >>> sh_amt;
   // Rotate: shift a doubled copy and keep the upper half.
   assign rol_ext = {s1_a_q, s1_a_q} << sh_amt;

   logic [WIDTH-1:0] ex_res;
   logic             ex_c;
   logic             ex_v;
   logic             ex_err;
   logic             ex_z;
   logic             ex_n;

   // Result and flag computation for the op held in S1
   always_comb begin
      ex_res = '0;
      ex_c   = 1'b0;
      ex_v   = 1'b0;
      ex_err = 1'b0;
      case (grp)
         GRP_ADD: begin
            if (!s1_op_q[0]) begin
               ex_res = add_sum[WIDTH-1:0];
               ex_c   = add_sum[WIDTH];
               ex_v   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                        (ex_res[WIDTH-1] != s1_a_q[WIDTH-1]);
            end else begin
               ex_res = sub_diff[WIDTH-1:0];
               ex_c   = sub_diff[WIDTH];
               ex_v   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                        (ex_res[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
         end
         GRP_BOOL: begin
            case (sub_op)
               BOOL_AND: ex_res = s1_a_q & s1_b_q;
               BOOL_OR:  ex_res = s1_a_q | s1_b_q;
               BOOL_XOR: ex_res = s1_a_q ^ s1_b_q;
               default:  ex_res = ~s1_a_q;
            endcase
         end
         GRP_SHIFT: begin
            case (sub_op)
               SH_SLL: begin
                  ex_res = sll_ext[WIDTH-1:0];
                  ex_c   = sll_ext[WIDTH];
               end
               SH_SRL: begin
                  ex_res = srl_ext[WIDTH:1];
                  ex_c   = srl_ext[0];
               end
               SH_SRA: begin
                  ex_res = sra_ext[WIDTH:1];
                  ex_c   = sra_ext[0];
               end
               default: begin
                  ex_res = rol_ext[2*WIDTH-1:WIDTH];
                  ex_c   = (sh_amt != '0) & rol_ext[WIDTH];
               end
            endcase
         end
         default: begin
            ex_err = 1'b1;
         end
      endcase
      // An illegal op reports all-zero flags, so Z is suppressed for it.
      ex_z = ~ex_err & (ex_res == '0);
      ex_n = ex_res[WIDTH-1];
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------

   // S1: load on acceptance, empty out once the op has moved on to S2
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = A;
         s1_b_d     = B;
         s1_op_d    = op;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // S2: capture the executed result; hold it while the consumer stalls
   always_comb begin
      s2_valid_d = s2_valid_q;
      out_d      = out_q;
      flags_d    = flags_q;
      err_d      = err_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         out_d      = ex_res;
         flags_d    = {ex_z, ex_n, ex_c, ex_v};
         err_d      = ex_err;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   // Carry register: only add-group ops leaving S1 update it
   always_comb begin
      carry_d = carry_q;
      if (s1_adv && (grp == GRP_ADD)) begin
         carry_d = ex_c;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------

   // Stage 1 input register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
      end
   end

   // Stage 2 result/flags register, drives the output port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         out_q      <= '0;
         flags_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         out_q      <= out_d;
         flags_q    <= flags_d;
         err_q      <= err_d;
      end
   end

   // Carry chain register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
      end else begin
         carry_q <= carry_d;
      end
   end

endmodule

// File: tb/tb_templatized_alu_pipe.sv
// Testbench for templatized_alu_pipe (WIDTH=16): table-driven vectors fed
// through a scoreboard, plus hand-written backpressure and reset sequences.
module tb_templatized_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;
   logic [3:0]  flags;
   logic        err;

   always #5 clk = ~clk;

   templatized_alu_pipe #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .flags(flags), .err(err)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_out;
      logic [3:0]  exp_flags;   // {Z,N,C,V}
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [15:0] out;
      logic [3:0]  flags;
      logic        err;
   } res_t;

   localparam int NV = 22;
   vec_t vecs [NV];
   res_t sb [$];
   res_t cur_exp;
   res_t held;
   bit   held_valid = 1'b0;
   bit   mark_first = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   first_out_cyc = 0;
   int   last_out_cyc = 0;
   int   out_cnt = 0;
   int   acc_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] e, input logic [3:0] f, input logic er);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.exp_out = e; v.exp_flags = f; v.exp_err = er;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: hold-stability check, scoreboard pop on output transfer, push on input acceptance
   always @(negedge clk) begin
      res_t e;
      if (out_valid && held_valid)
         chk("hold_stable", 32'({out, flags, err}), 32'(held));
      if (out_valid && !out_ready) begin
         held       = {out, flags, err};
         held_valid = 1'b1;
      end else begin
         held_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'({out, flags, err}), 32'hDEAD_0000);
         end else begin
            e = sb.pop_front();
            chk($sformatf("result%0d", out_cnt), 32'({out, flags, err}), 32'(e));
            $display("out #%0d: out=0x%04h flags=%04b err=%0b (exp 0x%04h %04b %0b)",
                     out_cnt, out, flags, err, e.out, e.flags, e.err);
         end
         out_cnt++;
         if (mark_first) begin
            first_out_cyc = cyc;
            mark_first    = 1'b0;
         end
         last_out_cyc = cyc;
      end
      if (in_valid && in_ready) begin
         sb.push_back(cur_exp);
         acc_cnt++;
      end
   end

   // Present one vector and hold it until accepted (bounded wait)
   task automatic send(input vec_t v);
      bit ok;
      in_valid = 1'b1;
      A        = v.a;
      B        = v.b;
      op       = v.op;
      cur_exp  = {v.exp_out, v.exp_flags, v.exp_err};
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until every expected result has been produced
   task automatic wait_drain(input string name);
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
      #1;
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      //            op       A        B        out      ZNCV     err
      vecs[0]  = mk(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0); // ADD -> Z,C
      vecs[1]  = mk(4'b0010, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0); // ADDC uses C=1
      vecs[2]  = mk(4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0); // SUB overflow
      vecs[3]  = mk(4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1'b0); // SUB borrow
      vecs[4]  = mk(4'b0011, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110, 1'b0); // SUBB with borrow
      vecs[5]  = mk(4'b1100, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1); // illegal
      vecs[6]  = mk(4'b0010, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0); // ADDC, carry kept
      vecs[7]  = mk(4'b1010, 16'h8001, 16'h0011, 16'hC000, 4'b0110, 1'b0); // SRA s=1
      vecs[8]  = mk(4'b1011, 16'h8001, 16'h0004, 16'h0018, 4'b0000, 1'b0); // ROL s=4
      vecs[9]  = mk(4'b1000, 16'hABCD, 16'h0010, 16'hABCD, 4'b0100, 1'b0); // SLL s=0
      vecs[10] = mk(4'b0100, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 1'b0); // AND
      vecs[11] = mk(4'b0101, 16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0100, 1'b0); // OR
      vecs[12] = mk(4'b0110, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1'b0); // XOR
      vecs[13] = mk(4'b0111, 16'h00FF, 16'h1234, 16'hFF00, 4'b0100, 1'b0); // NOT A
      vecs[14] = mk(4'b1001, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b0); // SRL s=1
      vecs[15] = mk(4'b1000, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0); // SLL s=1
      vecs[16] = mk(4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0); // ADD overflow
      vecs[17] = mk(4'b0011, 16'h0005, 16'h0003, 16'h0002, 4'b0000, 1'b0); // SUBB no borrow
      vecs[18] = mk(4'b0010, 16'hFFFF, 16'h0000, 16'hFFFF, 4'b0100, 1'b0); // ADDC carry 0
      vecs[19] = mk(4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1'b1); // illegal
      vecs[20] = mk(4'b1011, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b0); // ROL s=0
      vecs[21] = mk(4'b1010, 16'h7FF0, 16'h0004, 16'h07FF, 4'b0000, 1'b0); // SRA s=4

      rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = '0; out_ready = 1'b1; cur_exp = '0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out",       32'(out),       32'd0);
      chk("rst_flags",     32'(flags),     32'd0);
      chk("rst_err",       32'(err),       32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-rate stream of the whole table
      mark_first = 1'b1;
      for (int i = 0; i < NV; i++) send(vecs[i]);
      wait_drain("drain_table");
      chk("full_rate_span", 32'(last_out_cyc - first_out_cyc), 32'(NV - 1));

      // Backpressure: 5 ops with the consumer stalled for 4 cycles
      out_ready = 1'b0;
      base = acc_cnt;
      fork
         begin
            for (int i = 9; i < 14; i++) send(vecs[i]);
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_accepted", 32'(acc_cnt - base), 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain("drain_bp");
      chk("bp_total_accepted", 32'(acc_cnt - base), 32'd5);

      // Reset mid-flight: set carry to 1, then park two bool ops and reset
      send(vecs[0]);
      wait_drain("drain_pre_rst");
      out_ready = 1'b0;
      send(vecs[10]);
      send(vecs[11]);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out",       32'({out, flags, err}), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      // ADDC 0+0 must see the cleared carry: result 0, Z=1
      in_valid = 1'b1; A = '0; B = '0; op = 4'b0010;
      cur_exp  = {16'h0000, 4'b1000, 1'b0};
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_lat1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("post_rst_lat2", 32'(out_valid), 32'd1);
      repeat (4) @(negedge clk);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
